// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer blocks: sequencer state type and
// elaboration-time dimension helpers.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  // Number of window positions along one axis.
  function automatic int unsigned out_dim(input int unsigned img,
                                          input int unsigned k,
                                          input int unsigned stride);
    return (img - k) / stride + 1;
  endfunction

  // Address width for a memory of the given depth, never below one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  // Counter width able to hold 0..max, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max > 0) ? int'($clog2(max + 1)) : 1;
  endfunction

endpackage

// File: rtl/conv_window_sequencer_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and an at_max flag used
// to build a carry chain between nested loop indices.
module wrap_counter
  import cnn_pkg::*;
#(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  assign at_max = (cnt_q == W'(MAX));
  assign cnt    = cnt_q;

  // Next count: clear wins, otherwise step and wrap at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Streams the feature-map read addresses of a KxK window sliding over an
// IMG_H x IMG_W map with stride STRIDE, kx fastest, then ky, ox, oy.
module conv_window_sequencer
  import cnn_pkg::*;
#(
  parameter  int unsigned IMG_H  = 28,
  parameter  int unsigned IMG_W  = 28,
  parameter  int unsigned K      = 3,
  parameter  int unsigned STRIDE = 1,
  localparam int unsigned AW     = addr_w(IMG_H * IMG_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] addr,
  output logic          win_first,
  output logic          win_last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int unsigned OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int unsigned KW    = cnt_w(K - 1);
  localparam int unsigned OWW   = cnt_w(OUT_W - 1);
  localparam int unsigned OHW   = cnt_w(OUT_H - 1);

  typedef logic [AW:0] wide_t;

  seq_state_t state_d, state_q;
  logic       out_valid_d, out_valid_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;

  logic           hs;
  logic           clr;
  logic           kx_inc, ky_inc, ox_inc, oy_inc;
  logic           kx_max, ky_max, ox_max, oy_max;
  logic           last_hs;
  logic [KW-1:0]  kx, ky;
  logic [OWW-1:0] ox;
  logic [OHW-1:0] oy;
  wide_t          row, col, lin;

  assign hs      = out_valid_q & out_ready;
  assign clr     = abort | ((state_q == IDLE) & start);
  assign kx_inc  = hs;
  assign ky_inc  = kx_inc & kx_max;
  assign ox_inc  = ky_inc & ky_max;
  assign oy_inc  = ox_inc & ox_max;
  assign last_hs = oy_inc & oy_max;

  wrap_counter #(.MAX(K - 1), .W(KW)) u_kx (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(kx_inc), .cnt(kx), .at_max(kx_max)
  );
  wrap_counter #(.MAX(K - 1), .W(KW)) u_ky (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(ky_inc), .cnt(ky), .at_max(ky_max)
  );
  wrap_counter #(.MAX(OUT_W - 1), .W(OWW)) u_ox (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(ox_inc), .cnt(ox), .at_max(ox_max)
  );
  wrap_counter #(.MAX(OUT_H - 1), .W(OHW)) u_oy (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(oy_inc), .cnt(oy), .at_max(oy_max)
  );

  // Linear address straight from the registered indices, one bit of headroom.
  always_comb begin
    row = wide_t'(oy) * wide_t'(STRIDE) + wide_t'(ky);
    col = wide_t'(ox) * wide_t'(STRIDE) + wide_t'(kx);
    lin = row * wide_t'(IMG_W) + col;
  end

  assign addr      = AW'(lin);
  assign win_first = out_valid_q & (kx == '0) & (ky == '0);
  assign win_last  = out_valid_q & kx_max & ky_max;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Sequencer next state and registered outputs; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = RUN;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_hs) begin
          state_d = DONE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench: two sequencer instances (4x4/K3/S1 and 5x5/K3/S2)
// checked against an index-decomposition model of the scan order.
module tb_conv_window_sequencer;

  localparam int AH = 4, AWD = 4, AK = 3, AS = 1;
  localparam int A_OH = (AH - AK) / AS + 1;
  localparam int A_OW = (AWD - AK) / AS + 1;
  localparam int A_TOT = A_OH * A_OW * AK * AK;
  localparam int BH = 5, BWD = 5, BK = 3, BS = 2;
  localparam int B_OH = (BH - BK) / BS + 1;
  localparam int B_OW = (BWD - BK) / BS + 1;
  localparam int B_TOT = B_OH * B_OW * BK * BK;

  typedef struct {
    int addr;
    bit f;
    bit l;
  } elem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   clk_run = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic       start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic       valid_a, wf_a, wl_a, busy_a, done_a;
  logic [3:0] addr_a;
  logic       start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic       valid_b, wf_b, wl_b, busy_b, done_b;
  logic [4:0] addr_b;
  int         done_cnt_a = 0;
  int         done_cnt_b = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  conv_window_sequencer #(.IMG_H(AH), .IMG_W(AWD), .K(AK), .STRIDE(AS)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .out_valid(valid_a), .out_ready(ready_a), .addr(addr_a),
    .win_first(wf_a), .win_last(wl_a), .busy(busy_a), .done(done_a)
  );

  conv_window_sequencer #(.IMG_H(BH), .IMG_W(BWD), .K(BK), .STRIDE(BS)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .out_valid(valid_b), .out_ready(ready_b), .addr(addr_b),
    .win_first(wf_b), .win_last(wl_b), .busy(busy_b), .done(done_b)
  );

  // Element n of the scan, obtained by splitting n into (oy, ox, ky, kx).
  function automatic elem_t model_elem(int n, int img_w, int k, int s);
    elem_t e;
    int ow, kx, ky, ox, oy;
    ow = (img_w - k) / s + 1;
    kx = n % k;
    ky = (n / k) % k;
    ox = (n / (k * k)) % ow;
    oy = n / (k * k * ow);
    e.addr = (oy * s + ky) * img_w + ox * s + kx;
    e.f = (kx == 0) && (ky == 0);
    e.l = (kx == k - 1) && (ky == k - 1);
    return e;
  endfunction

  // Full scan on instance A; rnd toggles out_ready, poke raises start in RUN and DONE.
  task automatic scan_a(input bit rnd, input bit poke);
    int idx, cyc, nf, nl, d0;
    bit stalled;
    logic [3:0] h_addr;
    logic h_f, h_l;
    elem_t e;
    idx = 0; cyc = 0; nf = 0; nl = 0; stalled = 1'b0; d0 = done_cnt_a;
    h_addr = '0; h_f = 1'b0; h_l = 1'b0;
    @(negedge clk); start_a = 1'b1; ready_a = 1'b0;
    @(negedge clk); start_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || addr_a !== 4'd0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL a_latency: valid=%b addr=%0d busy=%b, required valid=1 addr=0 busy=1",
               valid_a, addr_a, busy_a);
    end
    while (idx < A_TOT && cyc < 4000) begin
      checks++;
      if (valid_a !== 1'b1) begin
        errors++;
        $display("FAIL a_valid idx=%0d: got %b, required 1", idx, valid_a);
      end
      if (stalled) begin
        checks++;
        if (addr_a !== h_addr || wf_a !== h_f || wl_a !== h_l) begin
          errors++;
          $display("FAIL a_stall_hold: addr=%0d f=%b l=%b, required addr=%0d f=%b l=%b",
                   addr_a, wf_a, wl_a, h_addr, h_f, h_l);
        end
      end
      start_a = poke && idx >= 5 && idx < 8;
      ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready_a) begin
        e = model_elem(idx, AWD, AK, AS);
        checks++;
        if (addr_a !== 4'(e.addr) || wf_a !== e.f || wl_a !== e.l) begin
          errors++;
          $display("FAIL a_elem idx=%0d: addr=%0d f=%b l=%b, required addr=%0d f=%b l=%b",
                   idx, addr_a, wf_a, wl_a, e.addr, e.f, e.l);
        end
        nf += int'(wf_a === 1'b1);
        nl += int'(wl_a === 1'b1);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        h_addr = addr_a; h_f = wf_a; h_l = wl_a;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL a_timeout: handshakes=%0d, required %0d", idx, A_TOT);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL a_done_cycle: done=%b busy=%b valid=%b, required 1 1 0",
               done_a, busy_a, valid_a);
    end
    start_a = poke;
    @(negedge clk); start_a = 1'b0;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL a_after_done: done=%b busy=%b valid=%b, required 0 0 0",
               done_a, busy_a, valid_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL a_idle_gap: busy=%b valid=%b, required 0 0", busy_a, valid_a);
    end
    checks++;
    if (done_cnt_a - d0 !== 1) begin
      errors++;
      $display("FAIL a_done_count: got %0d, required 1", done_cnt_a - d0);
    end
    checks++;
    if (nf !== A_OH * A_OW || nl !== A_OH * A_OW) begin
      errors++;
      $display("FAIL a_flag_count: first=%0d last=%0d, required %0d each", nf, nl, A_OH * A_OW);
    end
    ready_a = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (valid_a !== 1'b0 || addr_a !== 4'd0 || wf_a !== 1'b0 || wl_a !== 1'b0 ||
        busy_a !== 1'b0 || done_a !== 1'b0 || valid_b !== 1'b0 || addr_b !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: a v=%b addr=%0d f=%b l=%b busy=%b done=%b b v=%b addr=%0d, required all 0",
               valid_a, addr_a, wf_a, wl_a, busy_a, done_a, valid_b, addr_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: va=%b ba=%b vb=%b bb=%b, required 0", valid_a, busy_a, valid_b, busy_b);
    end
  endtask

  task automatic test_scan;
    scan_a(1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    scan_a(1'b1, 1'b0);
  endtask

  task automatic test_start_ignored;
    scan_a(1'b0, 1'b1);
  endtask

  task automatic test_abort;
    int hs, cyc, d0;
    elem_t e;
    hs = 0; cyc = 0; d0 = done_cnt_a;
    @(negedge clk); start_a = 1'b1; ready_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    while (hs < 10 && cyc < 100) begin
      if (valid_a === 1'b1) hs++;
      @(negedge clk);
      cyc++;
    end
    e = model_elem(10, AWD, AK, AS);
    checks++;
    if (valid_a !== 1'b1 || addr_a !== 4'(e.addr)) begin
      errors++;
      $display("FAIL abort_pre: valid=%b addr=%0d, required valid=1 addr=%0d", valid_a, addr_a, e.addr);
    end
    abort_a = 1'b1; ready_a = 1'b0;
    @(negedge clk); abort_a = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: valid=%b busy=%b done=%b, required 0 0 0", valid_a, busy_a, done_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_cnt_a !== d0) begin
      errors++;
      $display("FAIL abort_quiet: valid=%b busy=%b done_pulses=%0d, required 0 0 0",
               valid_a, busy_a, done_cnt_a - d0);
    end
    scan_a(1'b0, 1'b0);
  endtask

  task automatic test_stride;
    int idx, cyc, d0;
    int got[$];
    int tl[4];
    elem_t e;
    idx = 0; cyc = 0; d0 = done_cnt_b;
    tl[0] = 0; tl[1] = 2; tl[2] = 10; tl[3] = 12;
    @(negedge clk); start_b = 1'b1; ready_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    while (valid_b === 1'b1 && cyc < 1000) begin
      e = model_elem(idx, BWD, BK, BS);
      checks++;
      if (addr_b !== 5'(e.addr) || wf_b !== e.f || wl_b !== e.l) begin
        errors++;
        $display("FAIL b_elem idx=%0d: addr=%0d f=%b l=%b, required addr=%0d f=%b l=%b",
                 idx, addr_b, wf_b, wl_b, e.addr, e.f, e.l);
      end
      got.push_back(int'(addr_b));
      idx++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (idx !== B_TOT || done_b !== 1'b1) begin
      errors++;
      $display("FAIL b_count: handshakes=%0d done=%b, required %0d and 1", idx, done_b, B_TOT);
    end
    if (idx == B_TOT) begin
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (got[w * 9] !== tl[w]) begin
          errors++;
          $display("FAIL b_top_left w=%0d: got %0d, required %0d", w, got[w * 9], tl[w]);
        end
      end
      checks++;
      if (got[B_TOT - 1] !== 24) begin
        errors++;
        $display("FAIL b_last_addr: got %0d, required 24", got[B_TOT - 1]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_b !== 1'b0 || done_cnt_b - d0 !== 1) begin
      errors++;
      $display("FAIL b_done: busy=%b pulses=%0d, required 0 and 1", busy_b, done_cnt_b - d0);
    end
    ready_b = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk); start_a = 1'b1; ready_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: valid=%b busy=%b, required 1 1", valid_a, busy_a);
    end
    clk_run = 1'b0;
    ready_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || addr_a !== 4'd0 || wf_a !== 1'b0 || wl_a !== 1'b0 ||
        busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_values: v=%b addr=%0d f=%b l=%b busy=%b done=%b, required all 0",
               valid_a, addr_a, wf_a, wl_a, busy_a, done_a);
    end
    #4 rst_n = 1'b1;
    #1 clk_run = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || addr_a !== 4'd0) begin
      errors++;
      $display("FAIL areset_idle: valid=%b busy=%b addr=%0d, required 0 0 0", valid_a, busy_a, addr_a);
    end
    scan_a(1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_scan;
    test_backpressure;
    test_start_ignored;
    test_abort;
    test_stride;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Issues the pixel read sequence for a KxK convolution window sliding over an IMG_H x IMG_W feature map with stride STRIDE. It consumes a single start command and streams one feature-map address per accepted handshake to the line-buffer/feature RAM reader. It pulses done after the final element. It sits between the layer controller, which drives start and abort, and the feature-memory read port, which drives out_ready.

## Interface
- IMG_H, default 28: feature-map rows.
- IMG_W, default 28: feature-map columns.
- K, default 3: kernel side. Constraint: 1 ≤ K ≤ min(IMG_H, IMG_W).
- STRIDE, default 1: window step. Constraint: ≥ 1.
- Derived: OUT_H = (IMG_H-K)/STRIDE+1, OUT_W = (IMG_W-K)/STRIDE+1, using integer division. AW = max(1, $clog2(IMG_H*IMG_W)).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin a scan. Sampled only in IDLE.
- abort, in, 1: synchronous cancel. Takes precedence over start.
- out_valid, out, 1: an address is presented.
- out_ready, in, 1: the consumer accepts the address.
- addr, out, AW: linear pixel address, (oy*STRIDE+ky)*IMG_W + ox*STRIDE+kx.
- win_first, out, 1: marks the element with ky=0, kx=0.
- win_last, out, 1: marks the element with ky=K-1, kx=K-1.
- busy, out, 1: high when the state is not IDLE.
- done, out, 1: one-cycle pulse after the final handshake.

## Operation
- Loop order, kx fastest: kx 0..K-1, then ky 0..K-1, then ox 0..OUT_W-1, then oy 0..OUT_H-1.
- Total elements per scan: OUT_H*OUT_W*K*K.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0: clear all four indices and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - out_valid=1.
  - A handshake (out_valid & out_ready) advances the indices by one step.
  - A handshake on the final element (all indices at max) goes to DONE instead.
  - No handshake: addr, win_first and win_last hold stable.
- DONE: done=1 for exactly one cycle, out_valid=0, then go to IDLE.
- abort=1 in RUN or DONE: next state is IDLE, out_valid drops, done is not asserted, and indices are cleared.
- start while busy is ignored. It is not queued.
- Index wrap: each index counts to its max, then wraps to 0 and carries into the next-outer index.
- addr is computed from registered indices using an incremental or multiply form. Either way, addr is combinational from state, with no extra pipeline stage.
- Width rule: all intermediate arithmetic is done at AW+1 bits or wider. addr never exceeds IMG_H*IMG_W-1.
- K=1 case: win_first and win_last are both 1 on every element.

## Timing
- Reset values: state IDLE, out_valid 0, addr 0, win_first 0, win_last 0, busy 0, done 0.
- Latency: start sampled at edge t puts out_valid=1 with the first element (addr 0) after edge t.
- Throughput: one element per cycle while out_ready is held at 1.
- The final handshake occurs at edge n. done=1 and busy=1 from edge n to edge n+1. busy=0 after edge n+1.
- The earliest next start is sampled at edge n+2, so there is a minimum one-cycle gap in IDLE.
- out_ready is ignored while out_valid=0.
- Reset mid-scan (rst_n low) forces reset values immediately, independent of clk.

## Structure
- Shared package cnn_pkg holds:
  - the seq_state_t enum (IDLE, RUN, DONE);
  - the functions out_dim(img, k, stride) and addr_w(depth), shared with the other layer blocks.
- One sub-module, wrap_counter:
  - parameter MAX;
  - inputs clk, rst_n, clr, inc;
  - outputs cnt and at_max.
- Four wrap_counter instances are chained by at_max & inc for kx, ky, ox and oy.
- The FSM, address generation and flag logic live in the top module.

## Test plan
- IMG 4x4, K=3, S=1, out_ready tied to 1, single start.
  - Required: 36 handshakes.
  - First 9 addrs: 0,1,2,4,5,6,8,9,10.
  - Window 2 starts at 1. Final addr is 15.
  - win_first and win_last each pulse 4 times.
  - done pulses once, one cycle after the last handshake.
- IMG 5x5, K=3, S=2.
  - Required: OUT 2x2.
  - Window top-left addrs: 0, 2, 10, 12.
  - Last element addr is 24.
- Backpressure: toggle out_ready pseudo-randomly.
  - Required: addr, win_first and win_last stay stable while out_valid & !out_ready.
  - Sequence is identical to the no-stall run.
  - Element count is unchanged.
- start pulsed while in RUN, and start asserted in the DONE cycle.
  - Required: both are ignored. Exactly one scan and one done pulse.
- abort after 10 handshakes.
  - Required: out_valid=0 and busy=0 on the next cycle, with no done.
  - A subsequent start restarts at addr 0.
- Async reset asserted mid-scan, with clk stopped during assertion.
  - Required: all outputs reach reset values immediately.
  - After release, the block idles until start.
